oam_dma_sched: RTL and testbench

// Sequences OAM DMA on the external/VRAM CPU address busses. A write to FF46 arms a
// 160-byte copy from {src,8'h00} to OAM. One byte moves per M-cycle. The block drives
// dma_a and the dma_addr_ext/dma_addr_vram bus-steal selects consumed by the bus pages.
// It also blocks CPU bus access while a copy runs.

---
 rtl/dmg_dma_pkg.sv | 28 ++
 rtl/oam_dma_sched.sv | 131 +++++++++++++
 tb/tb_oam_dma_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmg_dma_pkg.sv
// rtl/dmg_dma_pkg.sv - shared types, constants and page folding for the OAM DMA scheduler
package dmg_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } dma_state_t;

  localparam int         DMA_LEN_DEF    = 160;
  localparam logic [7:0] VRAM_PAGE_LO   = 8'h80;
  localparam logic [7:0] VRAM_PAGE_HI   = 8'h9F;
  localparam logic [7:0] ECHO_PAGE_MASK = 8'h1F;
  localparam logic [7:0] ECHO_PAGE_BASE = 8'hC0;

  // Pages E0..FF mirror work RAM C0..DF when folding is enabled.
  function automatic logic [7:0] fold_page(input logic [7:0] page, input logic fold_en);
    if (fold_en && (page[7:5] == 3'b111)) begin
      return ECHO_PAGE_BASE | (page & ECHO_PAGE_MASK);
    end
    return page;
  endfunction

  function automatic logic is_vram_page(input logic [7:0] page);
    return (page >= VRAM_PAGE_LO) && (page <= VRAM_PAGE_HI);
  endfunction

endpackage

// File: rtl/oam_dma_sched.sv
// rtl/oam_dma_sched.sv - OAM DMA sequencer: FF46 arm, per-M-cycle byte copy, bus steal
module oam_dma_sched
  import dmg_dma_pkg::*;
#(
  parameter int DMA_LEN   = DMA_LEN_DEF,
  parameter int ARM_MCYC  = 1,
  parameter int ECHO_FOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mcyc_en,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  reg_q,
  input  logic [7:0]  bus_d,
  output logic [15:0] dma_a,
  output logic        dma_addr_ext,
  output logic        dma_addr_vram,
  output logic        oam_we,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_d,
  output logic        dma_busy
);

  localparam int         ACW      = (ARM_MCYC > 0) ? $clog2(ARM_MCYC + 1) : 1;
  localparam logic [ACW-1:0] ARM_INIT = ACW'(ARM_MCYC);
  localparam logic [ACW-1:0] ARM_ONE  = ACW'(1);
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  generate
    if (DMA_LEN < 1 || DMA_LEN > 256) begin : g_len_chk
      $error("oam_dma_sched: DMA_LEN must be in 1..256");
    end
    if (ARM_MCYC < 1) begin : g_arm_chk
      $error("oam_dma_sched: ARM_MCYC must be at least 1");
    end
  endgenerate

  dma_state_t     state, state_n;
  logic [7:0]     src, src_n;
  logic [7:0]     idx, idx_n;
  logic [ACW-1:0] arm_cnt, arm_cnt_n;
  logic           busy_hold, busy_hold_n;
  logic           wr_hit;
  logic           run;
  logic [7:0]     page;
  logic           unused_rd;

  // FF46 reads are pure readback; the strobe carries no state change.
  assign unused_rd = reg_rd;

  assign wr_hit = reg_wr && mcyc_en;
  assign run    = (state == RUN);
  assign page   = fold_page(src, ECHO_FOLD != 0);

  // State register and counters; reset wins over any same-clk M-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= 8'h00;
      idx       <= 8'h00;
      arm_cnt   <= '0;
      busy_hold <= 1'b0;
    end else begin
      state     <= state_n;
      src       <= src_n;
      idx       <= idx_n;
      arm_cnt   <= arm_cnt_n;
      busy_hold <= busy_hold_n;
    end
  end

  // Next-state: arm on FF46 write, count down arm delay, step one byte per M-cycle.
  always_comb begin
    state_n     = state;
    src_n       = src;
    idx_n       = idx;
    arm_cnt_n   = arm_cnt;
    busy_hold_n = busy_hold;
    case (state)
      IDLE: begin
        if (wr_hit) begin
          src_n       = cpu_d;
          arm_cnt_n   = ARM_INIT;
          busy_hold_n = 1'b0;
          state_n     = ARM;
        end
      end
      ARM: begin
        if (wr_hit) begin
          src_n     = cpu_d;
          arm_cnt_n = ARM_INIT;
        end else if (mcyc_en) begin
          arm_cnt_n = arm_cnt - ARM_ONE;
          if (arm_cnt == ARM_ONE) begin
            state_n = RUN;
            idx_n   = 8'h00;
          end
        end
      end
      RUN: begin
        if (mcyc_en) begin
          idx_n = idx + 8'h01;
          if (wr_hit) begin
            // The byte closing this M-cycle is still written; the new copy starts from 0.
            src_n       = cpu_d;
            arm_cnt_n   = ARM_INIT;
            busy_hold_n = 1'b1;
            idx_n       = 8'h00;
            state_n     = ARM;
          end else if (idx == LAST_IDX) begin
            idx_n   = 8'h00;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign reg_q         = src;
  assign dma_a         = run ? {page, idx} : 16'h0000;
  assign dma_addr_vram = run && is_vram_page(page);
  assign dma_addr_ext  = run && !is_vram_page(page);
  assign oam_we        = run && mcyc_en;
  assign oam_a         = oam_we ? idx : 8'h00;
  assign oam_d         = oam_we ? bus_d : 8'h00;
  assign dma_busy      = run || ((state == ARM) && busy_hold);

endmodule

// File: tb/tb_oam_dma_sched.sv
// tb/tb_oam_dma_sched.sv - directed vector bench for oam_dma_sched
module tb_oam_dma_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mcyc_en = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [7:0]  cpu_d = 8'h00;
  logic [7:0]  bus_d = 8'h00;
  logic [7:0]  reg_q;
  logic [15:0] dma_a;
  logic        dma_addr_ext;
  logic        dma_addr_vram;
  logic        oam_we;
  logic [7:0]  oam_a;
  logic [7:0]  oam_d;
  logic        dma_busy;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  typedef struct {
    logic        rst, wr, men;
    logic [7:0]  d, bd;
    logic [15:0] a;
    logic        ext, vram, we;
    logic [7:0]  oa, od;
    logic        busy;
    logic [7:0]  q;
  } vec_t;

  vec_t tbl [18];

  oam_dma_sched dut (
    .clk(clk), .reset(reset), .mcyc_en(mcyc_en), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .cpu_d(cpu_d), .reg_q(reg_q), .bus_d(bus_d), .dma_a(dma_a),
    .dma_addr_ext(dma_addr_ext), .dma_addr_vram(dma_addr_vram), .oam_we(oam_we),
    .oam_a(oam_a), .oam_d(oam_d), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; reg_wr = 1'b0; mcyc_en = 1'b0; reg_rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One M-cycle of 4 clks, mcyc_en on the last; checks bus outputs every clk.
  task automatic mcyc(input logic wr, input logic [7:0] d, input logic run,
                      input logic [15:0] ea, input logic vram, input logic busy);
    logic [7:0] bd;
    for (int c = 0; c < 4; c++) begin
      bd = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      reset = 1'b0; mcyc_en = (c == 3); reg_wr = (c == 3) && wr;
      reg_rd = (c == 1); cpu_d = d; bus_d = bd;
      @(negedge clk);
      chk("dma_a", dma_a, ea);
      chk("dma_addr_ext", 16'(dma_addr_ext), 16'(run & ~vram));
      chk("dma_addr_vram", 16'(dma_addr_vram), 16'(run & vram));
      chk("dma_busy", 16'(dma_busy), 16'(busy));
      chk("oam_we", 16'(oam_we), 16'(run && (c == 3)));
      if (run && (c == 3)) begin
        chk("oam_a", 16'(oam_a), 16'(ea[7:0]));
        chk("oam_d", 16'(oam_d), 16'(bd));
      end
    end
  endtask

  // Complete copy from IDLE: write, one arm M-cycle, 160 transfers, back to idle.
  task automatic copy(input logic [7:0] w, input logic [7:0] fp, input logic vram);
    mcyc(H, w, L, 16'h0000, L, L);
    mcyc(L, 8'h00, L, 16'h0000, L, L);
    chk("reg_q", 16'(reg_q), 16'(w));
    for (int k = 0; k < 160; k++) mcyc(L, 8'h00, H, {fp, 8'(k)}, vram, H);
    mcyc(L, 8'h00, L, 16'h0000, L, L);
    chk("reg_q_after", 16'(reg_q), 16'(w));
  endtask

  initial begin
    //          rst wr men d      bd     a         ext vram we oa     od     busy q
    tbl[0]  = '{L, L, L, 8'h00, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, L, 8'h00};
    tbl[1]  = '{L, H, L, 8'h55, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, L, 8'h00};
    tbl[2]  = '{L, H, H, 8'hC1, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, L, 8'h00};
    tbl[3]  = '{L, L, H, 8'h00, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, L, 8'hC1};
    tbl[4]  = '{L, L, H, 8'h00, 8'hA5, 16'hC100, H, L, H, 8'h00, 8'hA5, H, 8'hC1};
    tbl[5]  = '{L, L, L, 8'h00, 8'h3C, 16'hC101, H, L, L, 8'h00, 8'h00, H, 8'hC1};
    tbl[6]  = '{L, L, H, 8'h00, 8'h3C, 16'hC101, H, L, H, 8'h01, 8'h3C, H, 8'hC1};
    tbl[7]  = '{L, H, H, 8'h8A, 8'h77, 16'hC102, H, L, H, 8'h02, 8'h77, H, 8'hC1};
    tbl[8]  = '{L, L, L, 8'h00, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, H, 8'h8A};
    tbl[9]  = '{L, H, H, 8'hE3, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, H, 8'h8A};
    tbl[10] = '{L, L, H, 8'h00, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, H, 8'hE3};
    tbl[11] = '{L, L, L, 8'h00, 8'h12, 16'hC300, H, L, L, 8'h00, 8'h00, H, 8'hE3};
    tbl[12] = '{L, L, H, 8'h00, 8'h12, 16'hC300, H, L, H, 8'h00, 8'h12, H, 8'hE3};
    tbl[13] = '{H, L, H, 8'h00, 8'hFF, 16'hC301, H, L, H, 8'h01, 8'hFF, H, 8'hE3};
    tbl[14] = '{L, L, H, 8'h00, 8'hFF, 16'h0000, L, L, L, 8'h00, 8'h00, L, 8'h00};
    tbl[15] = '{L, H, H, 8'h8A, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, L, 8'h00};
    tbl[16] = '{L, L, H, 8'h00, 8'h00, 16'h0000, L, L, L, 8'h00, 8'h00, L, 8'h8A};
    tbl[17] = '{L, L, H, 8'h00, 8'h5A, 16'h8A00, L, H, H, 8'h00, 8'h5A, H, 8'h8A};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      reset = tbl[i].rst; reg_wr = tbl[i].wr; mcyc_en = tbl[i].men;
      cpu_d = tbl[i].d; bus_d = tbl[i].bd; reg_rd = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d.dma_a", i), dma_a, tbl[i].a);
      chk($sformatf("v%0d.ext", i), 16'(dma_addr_ext), 16'(tbl[i].ext));
      chk($sformatf("v%0d.vram", i), 16'(dma_addr_vram), 16'(tbl[i].vram));
      chk($sformatf("v%0d.oam_we", i), 16'(oam_we), 16'(tbl[i].we));
      chk($sformatf("v%0d.oam_a", i), 16'(oam_a), 16'(tbl[i].oa));
      chk($sformatf("v%0d.oam_d", i), 16'(oam_d), 16'(tbl[i].od));
      chk($sformatf("v%0d.busy", i), 16'(dma_busy), 16'(tbl[i].busy));
      chk($sformatf("v%0d.reg_q", i), 16'(reg_q), 16'(tbl[i].q));
    end

    // Full copies: external, VRAM and echo-folded sources.
    do_reset();
    copy(8'hC1, 8'hC1, L);
    copy(8'h8A, 8'h8A, H);
    copy(8'hE3, 8'hC3, L);

    // Restart at idx 50, then restart again on the last byte of the second copy.
    mcyc(H, 8'hC0, L, 16'h0000, L, L);
    mcyc(L, 8'h00, L, 16'h0000, L, L);
    for (int k = 0; k < 50; k++) mcyc(L, 8'h00, H, {8'hC0, 8'(k)}, L, H);
    mcyc(H, 8'hD0, H, 16'hC032, L, H);
    mcyc(L, 8'h00, L, 16'h0000, L, H);
    for (int k = 0; k < 159; k++) mcyc(L, 8'h00, H, {8'hD0, 8'(k)}, L, H);
    mcyc(H, 8'h8A, H, 16'hD09F, L, H);
    mcyc(L, 8'h00, L, 16'h0000, L, H);
    for (int k = 0; k < 160; k++) mcyc(L, 8'h00, H, {8'h8A, 8'(k)}, H, H);
    mcyc(L, 8'h00, L, 16'h0000, L, L);

    // Reset in the middle of a copy, then an FF46 write without an M-cycle strobe.
    mcyc(H, 8'hC1, L, 16'h0000, L, L);
    mcyc(L, 8'h00, L, 16'h0000, L, L);
    for (int k = 0; k < 100; k++) mcyc(L, 8'h00, H, {8'hC1, 8'(k)}, L, H);
    @(posedge clk); #1;
    reset = 1'b1; mcyc_en = 1'b0; reg_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; mcyc_en = 1'b1; bus_d = 8'h99;
    @(negedge clk);
    chk("rst.dma_a", dma_a, 16'h0000);
    chk("rst.ext", 16'(dma_addr_ext), 16'h0000);
    chk("rst.vram", 16'(dma_addr_vram), 16'h0000);
    chk("rst.oam_we", 16'(oam_we), 16'h0000);
    chk("rst.oam_a", 16'(oam_a), 16'h0000);
    chk("rst.oam_d", 16'(oam_d), 16'h0000);
    chk("rst.busy", 16'(dma_busy), 16'h0000);
    chk("rst.reg_q", 16'(reg_q), 16'h0000);
    @(posedge clk); #1;
    mcyc_en = 1'b0; reg_wr = 1'b1; cpu_d = 8'hC5;
    @(posedge clk); #1;
    reg_wr = 1'b0;
    @(negedge clk);
    chk("nowr.reg_q", 16'(reg_q), 16'h0000);
    mcyc(L, 8'h00, L, 16'h0000, L, L);
    mcyc(L, 8'h00, L, 16'h0000, L, L);
    chk("nowr.reg_q_late", 16'(reg_q), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
